// File: rtl/freelist_if.sv
// Rename/commit port bundle for the physical register free list.
// Allocation outputs are combinational from the list state; commit inputs are sampled on the clock.
interface freelist_if #(
    parameter int WIDTH_REG = 7
);
    logic [3:0]             i_alloc_mask;
    logic                   i_alloc_en;
    logic [4*WIDTH_REG-1:0] o_alloc_prd4x;
    logic                   o_alloc_rdy;
    logic [4*WIDTH_REG-1:0] i_com_prd4x;
    logic [3:0]             i_com_mask;
    logic                   i_com_en;
    logic [WIDTH_REG:0]     o_free_cnt;
    logic                   o_err;

    modport slave (
        input  i_alloc_mask, i_alloc_en, i_com_prd4x, i_com_mask, i_com_en,
        output o_alloc_prd4x, o_alloc_rdy, o_free_cnt, o_err
    );

    modport master (
        output i_alloc_mask, i_alloc_en, i_com_prd4x, i_com_mask, i_com_en,
        input  o_alloc_prd4x, o_alloc_rdy, o_free_cnt, o_err
    );
endinterface

// File: rtl/freelist.sv
// Circular free list of physical register tags: 4-wide compacted pop for rename, 4-wide compacted push from commit.
// Zero-cycle allocation lookup; a group that cannot be fully served is refused (rdy=0) and flagged if forced.
module freelist #(
    parameter int WIDTH_REG = 7,
    parameter int NARCH     = 32
) (
    input  logic      i_clk,
    input  logic      i_rst,
    freelist_if.slave fl
);
    localparam int NPREG = 1 << WIDTH_REG;
    localparam int CW    = WIDTH_REG + 1;
    localparam int SW    = CW + 1;

    logic [WIDTH_REG-1:0] mem [NPREG];
    logic [WIDTH_REG-1:0] head;
    logic [WIDTH_REG-1:0] tail;
    logic [CW-1:0]        count;
    logic                 err;

    logic [2:0]           alloc_off [4];
    logic [2:0]           push_off  [4];
    logic [3:0]           push_vld;
    logic [2:0]           alloc_n;
    logic [2:0]           push_n;
    logic [2:0]           a_acc;
    logic [2:0]           p_acc;
    logic [2:0]           pop_n;
    logic [SW-1:0]        cnt_sum;
    logic                 rdy;
    logic                 do_pop;
    logic                 alloc_fail;
    logic                 overflow;
    logic                 do_push;
    logic [4*WIDTH_REG-1:0] prd;

    // Prefix popcounts give each lane its compacted slot offset.
    always_comb begin
        a_acc    = '0;
        p_acc    = '0;
        push_vld = '0;
        for (int i = 0; i < 4; i++) begin
            alloc_off[i] = a_acc;
            if (fl.i_alloc_mask[i]) a_acc = a_acc + 3'd1;
            push_vld[i] = fl.i_com_en & fl.i_com_mask[i] &
                          (fl.i_com_prd4x[i*WIDTH_REG +: WIDTH_REG] != '0);
            push_off[i] = p_acc;
            if (push_vld[i]) p_acc = p_acc + 3'd1;
        end
        alloc_n = a_acc;
        push_n  = p_acc;
    end

    always_comb begin
        prd = '0;
        for (int i = 0; i < 4; i++) begin
            if (fl.i_alloc_mask[i])
                prd[i*WIDTH_REG +: WIDTH_REG] = mem[head + WIDTH_REG'(alloc_off[i])];
        end
    end

    // A refused allocation freezes the whole update, commit included, and only raises err.
    always_comb begin
        rdy        = (count >= CW'(alloc_n));
        do_pop     = fl.i_alloc_en & rdy;
        alloc_fail = fl.i_alloc_en & ~rdy;
        pop_n      = do_pop ? alloc_n : 3'd0;
        cnt_sum    = {1'b0, count} - SW'(pop_n) + SW'(push_n);
        overflow   = (push_n != 3'd0) && (cnt_sum > SW'(NPREG - 1));
        do_push    = (push_n != 3'd0) & ~overflow & ~alloc_fail;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NPREG; k++)
                mem[k] <= (k < NPREG - NARCH) ? WIDTH_REG'(NARCH + k) : '0;
            head  <= '0;
            tail  <= WIDTH_REG'(NPREG - NARCH);
            count <= CW'(NPREG - NARCH);
            err   <= 1'b0;
        end else begin
            if (!alloc_fail) begin
                if (do_pop) head <= head + WIDTH_REG'(alloc_n);
                if (do_push) begin
                    for (int i = 0; i < 4; i++) begin
                        if (push_vld[i])
                            mem[tail + WIDTH_REG'(push_off[i])] <=
                                fl.i_com_prd4x[i*WIDTH_REG +: WIDTH_REG];
                    end
                    tail <= tail + WIDTH_REG'(push_n);
                end
                count <= count - CW'(pop_n) + (do_push ? CW'(push_n) : CW'(0));
            end
            if (alloc_fail || overflow) err <= 1'b1;
        end
    end

    assign fl.o_alloc_prd4x = prd;
    assign fl.o_alloc_rdy   = rdy;
    assign fl.o_free_cnt    = count;
    assign fl.o_err         = err;
endmodule
